// File: rtl/vc_control.sv
// Victim-cache controller: lookup, true-LRU victim choice, dirty writeback,
// refill from memory and the L1<->VC line swap for a 4-way exclusive victim cache.
module vc_control #(
    parameter int TAG_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 l1_req,
    input  logic [TAG_WIDTH-1:0] l1_addr,
    input  logic                 l1_evict_valid,
    input  logic                 l1_evict_dirty,
    input  logic [TAG_WIDTH-1:0] l1_evict_tag,
    output logic                 l1_resp,
    output logic                 l1_src_sel,
    input  logic [TAG_WIDTH-1:0] tag0,
    input  logic [TAG_WIDTH-1:0] tag1,
    input  logic [TAG_WIDTH-1:0] tag2,
    input  logic [TAG_WIDTH-1:0] tag3,
    output logic [1:0]           array_index,
    output logic                 array_write,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [TAG_WIDTH-1:0] pmem_addr,
    input  logic                 pmem_resp
);
    typedef enum logic [2:0] {IDLE, LOOKUP, WB, FETCH, SWAP} state_t;

    state_t                    state, state_nx;
    logic [TAG_WIDTH-1:0]      addr_r, ev_tag_r;
    logic                      ev_valid_r, ev_dirty_r;
    logic [3:0]                valid, dirty;
    logic [3:0][1:0]           rank;
    logic [1:0]                way_r;
    logic                      hit_r;

    logic [3:0][TAG_WIDTH-1:0] tags;
    logic [3:0]                match;
    logic                      hit;
    logic [1:0]                hit_way, inv_way, lru_way, vic_way;

    assign tags = {tag3, tag2, tag1, tag0};

    for (genvar w = 0; w < 4; w++) begin : g_match
        assign match[w] = valid[w] && (tags[w] == addr_r);
    end

    // Descending scans leave the lowest qualifying way selected.
    always_comb begin
        hit_way = 2'd0;
        inv_way = 2'd0;
        lru_way = 2'd0;
        for (int w = 3; w >= 0; w--) begin
            if (match[w])      hit_way = 2'(w);
            if (!valid[w])     inv_way = 2'(w);
            if (rank[w] == 2'd0) lru_way = 2'(w);
        end
        hit     = |match;
        vic_way = hit ? hit_way : ((&valid) ? lru_way : inv_way);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (l1_req) state_nx = LOOKUP;
            LOOKUP: begin
                if (hit)                                 state_nx = SWAP;
                else if (valid[vic_way] && dirty[vic_way]) state_nx = WB;
                else                                     state_nx = FETCH;
            end
            WB:      if (pmem_resp) state_nx = FETCH;
            FETCH:   if (pmem_resp) state_nx = SWAP;
            SWAP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Moore outputs; everything idles at zero so reset forces them low at once.
    always_comb begin
        l1_resp     = 1'b0;
        l1_src_sel  = 1'b0;
        array_index = 2'd0;
        array_write = 1'b0;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        pmem_addr   = '0;
        case (state)
            WB: begin
                pmem_write  = 1'b1;
                pmem_addr   = tags[way_r];
                array_index = way_r;
            end
            FETCH: begin
                pmem_read = 1'b1;
                pmem_addr = addr_r;
            end
            SWAP: begin
                l1_resp     = 1'b1;
                l1_src_sel  = ~hit_r;
                array_index = way_r;
                array_write = ev_valid_r;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            dirty      <= '0;
            rank       <= {2'd3, 2'd2, 2'd1, 2'd0};
            addr_r     <= '0;
            ev_tag_r   <= '0;
            ev_valid_r <= 1'b0;
            ev_dirty_r <= 1'b0;
            way_r      <= 2'd0;
            hit_r      <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (l1_req) begin
                    addr_r     <= l1_addr;
                    ev_valid_r <= l1_evict_valid;
                    ev_dirty_r <= l1_evict_dirty;
                    ev_tag_r   <= l1_evict_tag;
                end
                LOOKUP: begin
                    way_r <= vic_way;
                    hit_r <= hit;
                end
                SWAP: begin
                    if (ev_valid_r) begin
                        valid[way_r] <= 1'b1;
                        dirty[way_r] <= ev_dirty_r;
                        for (int w = 0; w < 4; w++) begin
                            if (2'(w) == way_r)          rank[w] <= 2'd3;
                            else if (rank[w] > rank[way_r]) rank[w] <= rank[w] - 2'd1;
                        end
                    end else if (hit_r) begin
                        // Line moved back to L1 with nothing to replace it.
                        valid[way_r] <= 1'b0;
                        dirty[way_r] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vc_control.sv
// Bench for vc_control: directed and random transactions against a list-based
// LRU reference model, with a simple tag-array and memory responder.
module tb_vc_control;
    localparam int TW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          l1_req, l1_evict_valid, l1_evict_dirty;
    logic [TW-1:0] l1_addr, l1_evict_tag;
    logic          l1_resp, l1_src_sel;
    logic [1:0]    array_index;
    logic          array_write, pmem_read, pmem_write, pmem_resp;
    logic [TW-1:0] pmem_addr;
    logic [TW-1:0] tagarr [4];

    int total = 0, passed = 0, failed = 0;

    // reference model: per-way contents plus ways ordered least- to most-recent
    bit            mvalid [4];
    bit            mdirty [4];
    logic [TW-1:0] mtag   [4];
    int            lru [$];

    always #5 clk = ~clk;

    always @(posedge clk) if (array_write) tagarr[array_index] <= l1_evict_tag;

    vc_control #(.TAG_WIDTH(TW)) dut (
        .clk(clk), .rst(rst), .l1_req(l1_req), .l1_addr(l1_addr),
        .l1_evict_valid(l1_evict_valid), .l1_evict_dirty(l1_evict_dirty),
        .l1_evict_tag(l1_evict_tag), .l1_resp(l1_resp), .l1_src_sel(l1_src_sel),
        .tag0(tagarr[0]), .tag1(tagarr[1]), .tag2(tagarr[2]), .tag3(tagarr[3]),
        .array_index(array_index), .array_write(array_write),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
        .pmem_resp(pmem_resp)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 4; w++) begin
            mvalid[w] = 0;
            mdirty[w] = 0;
        end
        lru = {0, 1, 2, 3};
    endtask

    task automatic touch(input int w);
        for (int i = 0; i < lru.size(); i++)
            if (lru[i] == w) begin
                lru.delete(i);
                break;
            end
        lru.push_back(w);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_resp"},  l1_resp, 0);
        chk({tag, "_pread"}, pmem_read, 0);
        chk({tag, "_pwr"},   pmem_write, 0);
        chk({tag, "_awr"},   array_write, 0);
        chk({tag, "_idx"},   array_index, 0);
        chk({tag, "_paddr"}, pmem_addr, 0);
    endtask

    function automatic bit in_vc(input logic [TW-1:0] t);
        for (int w = 0; w < 4; w++) if (mvalid[w] && mtag[w] == t) return 1;
        return 0;
    endfunction

    // One L1 miss transaction; called on a negedge, returns on a negedge.
    task automatic txn(input logic [TW-1:0] a, input bit ev, input bit evd,
                       input logic [TW-1:0] et, input bit abort_wb);
        int            way, cyc, lat, bc;
        bit            hit, wb, done, wb_seen, rd_seen;
        logic [TW-1:0] wbaddr;
        hit = 0;
        way = -1;
        for (int w = 0; w < 4; w++)
            if (!hit && mvalid[w] && mtag[w] == a) begin
                hit = 1;
                way = w;
            end
        if (!hit) begin
            for (int w = 0; w < 4; w++) if (way < 0 && !mvalid[w]) way = w;
            if (way < 0) way = lru[0];
        end
        wb     = !hit && mvalid[way] && mdirty[way];
        wbaddr = mtag[way];

        l1_req = 1; l1_addr = a; l1_evict_valid = ev; l1_evict_dirty = evd; l1_evict_tag = et;
        cyc = 1; done = 0; wb_seen = 0; rd_seen = 0; bc = 0;
        lat = $urandom_range(1, 4);
        while (!done && cyc < 300) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            pmem_resp = 0;
            if (l1_resp) begin
                chk("swap_idx", array_index, 32'(way));
                chk("src_sel",  l1_src_sel, !hit);
                chk("arr_wr",   array_write, ev);
                chk("wb_seen",  wb_seen, wb);
                chk("rd_seen",  rd_seen, !hit);
                if (hit) chk("hit_latency", cyc, 3);
                l1_req = 0;
                done = 1;
            end else if (pmem_write || pmem_read) begin
                chk("pmem_excl", pmem_read & pmem_write, 0);
                if (pmem_write && !wb_seen) begin
                    wb_seen = 1;
                    chk("wb_addr",  pmem_addr, wbaddr);
                    chk("wb_index", array_index, 32'(way));
                    if (abort_wb) begin
                        #2 rst = 1;
                        #1 chk_idle_outputs("rst_wb");
                        model_reset();
                        l1_req = 0;
                        @(negedge clk) rst = 0;
                        return;
                    end
                end
                if (pmem_read && !rd_seen) begin
                    rd_seen = 1;
                    chk("rd_addr",     pmem_addr, a);
                    chk("wb_before_rd", wb_seen, wb);
                end
                // registered request must not follow later changes of l1_addr
                if (pmem_read) begin
                    chk("rd_addr_hold", pmem_addr, a);
                    l1_addr = TW'($urandom);
                end
                bc++;
                if (bc >= lat) begin
                    pmem_resp = 1;
                    bc = 0;
                    lat = $urandom_range(1, 4);
                end
            end
        end
        chk("txn_done", done, 1);
        if (ev) begin
            mvalid[way] = 1;
            mdirty[way] = evd;
            mtag[way]   = et;
            touch(way);
        end else if (hit) begin
            mvalid[way] = 0;
            mdirty[way] = 0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("resp_once", l1_resp, 0);
    endtask

    initial begin
        logic [TW-1:0] a, et;
        bit            ev;
        rst = 1; l1_req = 0; l1_addr = '0; l1_evict_valid = 0; l1_evict_dirty = 0;
        l1_evict_tag = '0; pmem_resp = 0;
        model_reset();
        #1 chk_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);

        // fill ways 0..3 with dirty lines, no writeback expected
        for (int i = 0; i < 4; i++) txn(TW'(12'h010 + i), 1, 1, TW'(12'h100 + i), 0);
        // hit with clean eviction
        txn(12'h101, 1, 0, 12'h200, 0);
        // dirty LRU victim: writeback then fetch
        txn(12'h050, 1, 1, 12'h300, 0);
        // hit without eviction invalidates, next miss reuses that way
        txn(12'h102, 0, 0, 12'h000, 0);
        txn(12'h060, 1, 0, 12'h400, 0);

        // spurious memory responses while idle
        for (int i = 0; i < 3; i++) begin
            pmem_resp = 1;
            @(negedge clk);
            chk_idle_outputs("spurious");
        end
        pmem_resp = 0;

        for (int n = 0; n < 60; n++) begin
            a  = TW'($urandom_range(12'h020, 12'h02f));
            ev = ($urandom_range(0, 4) != 0);
            do et = TW'($urandom_range(12'h020, 12'h02f)); while (in_vc(et) || et == a);
            txn(a, ev, bit'($urandom_range(0, 1)), et, 0);
        end

        // reset in the middle of a writeback
        rst = 1;
        @(negedge clk);
        rst = 0;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) txn(TW'(12'h070 + i), 1, 1, TW'(12'h080 + i), 0);
        txn(12'h090, 1, 1, 12'h0a0, 1);
        @(negedge clk);
        chk_idle_outputs("post_rst");
        // tags are still in the array, but reset invalidated them
        txn(12'h081, 1, 0, 12'h0b0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
